// File: rtl/uart_rx_deser_if.sv
// Receiver-to-FIFO write port: byte, write strobe and full back-pressure.
// master = the receiver that produces bytes, slave = the FIFO that stores them.
interface uart_rx_deser_if;
  logic [7:0] data;
  logic       wrreq;
  logic       full;

  modport master (output data, output wrreq, input full);
  modport slave  (input data, input wrreq, output full);
endinterface

// File: rtl/uart_rx_deser.sv
// UART receiver that deserialises 8N1 frames, LSB first, into single-cycle
// FIFO writes. Bytes are dropped with a sticky overrun flag when the FIFO is full.
// Optional macro UART_RX_PARITY_EN adds a parity bit (8E1/8O1 chosen by PARITY_ODD).
module uart_rx_deser #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic            clock,
  input  logic            sclr,
  input  logic            rx,
  uart_rx_deser_if.master fifo,
  output logic            busy,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rx_s;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          par_bad;
  logic          tick;
  logic          write_now, ferr_now, perr_now, ovr_now;

  assign tick = (bit_cnt == MID);

  // Two-flop synchroniser for the asynchronous line; idles high so reset looks like an idle line
  always_ff @(posedge clock) begin
    if (sclr) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (sclr) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; IDLE is only ever entered with rx_s high, so a low level there is a falling edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!rx_s) state_nxt = START;
      START: if (tick)  state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (tick && idx == 3'd7) state_nxt = PARITY;
      PARITY: if (tick) state_nxt = STOP;
`else
      DATA:  if (tick && idx == 3'd7) state_nxt = STOP;
`endif
      STOP:  if (tick)  state_nxt = rx_s ? IDLE : BREAK;
      BREAK: if (rx_s)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stop-bit verdict in priority order: framing, parity, back-pressure, then a good write
  always_comb begin
    busy      = (state != IDLE);
    write_now = 1'b0;
    ferr_now  = 1'b0;
    perr_now  = 1'b0;
    ovr_now   = 1'b0;
    if (state == STOP && tick) begin
      if (!rx_s)         ferr_now  = 1'b1;
      else if (par_bad)  perr_now  = 1'b1;
      else if (fifo.full) ovr_now  = 1'b1;
      else               write_now = 1'b1;
    end
  end

  // Bit timing, data shifting and registered outputs; the counter free-runs so mid-bit alignment carries from the start bit
  always_ff @(posedge clock) begin
    if (sclr) begin
      bit_cnt    <= '0;
      idx        <= '0;
      shift      <= '0;
      fifo.data  <= '0;
      fifo.wrreq <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (state == IDLE)        bit_cnt <= '0;
      else if (bit_cnt == LAST) bit_cnt <= '0;
      else                      bit_cnt <= bit_cnt + 1'b1;

      if (state == START && tick) idx <= '0;
      if (state == DATA && tick) begin
        shift <= {rx_s, shift[7:1]};
        idx   <= idx + 3'd1;
      end

      fifo.wrreq <= write_now;
      frame_err  <= ferr_now;
      parity_err <= perr_now;
      if (write_now) fifo.data <= shift;
      if (ovr_now)   overrun   <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Compare the received parity bit against the expected one and remember a mismatch until stop
  always_ff @(posedge clock) begin
    if (sclr)                       par_bad <= 1'b0;
    else if (state == START)        par_bad <= 1'b0;
    else if (state == PARITY && tick) par_bad <= rx_s ^ (^shift) ^ PARITY_ODD;
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign par_bad           = 1'b0;
`endif

endmodule
